booth_controller: RTL
=====================

BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 Parameter: BIT, default 8, operand width in bits.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 a_in  in  BIT  multiplicand, signed two's complement; captured with start.
REQ-006 b_in  in  BIT  multiplier, signed; captured with start.
REQ-007 count  in  BIT  datapath iteration counter value.
REQ-008 cmp  in  2  datapath {Q[0], Q0} Booth pair.
REQ-009 data  out  BIT  operand bus to datapath.
REQ-010 ldA, ldB, ldM, ldQ, ldQ0, ldC, countdown  out  1 each  datapath load/decrement strobes.
REQ-011 selM  out  2  M source: 00 data, 01 M+A, 10 M-A, 11 shifter high half.
REQ-012 selQ  out  1  Q source: 0 data, 1 shifter low half.
REQ-013 dp_clr  out  1  one-cycle clear of all datapath registers.
REQ-014 busy  out  1  high from the cycle after start is accepted until DONE is left.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  valid with done; iteration limit hit with count != 0.

Function
REQ-017 States: IDLE, CLR, LDA, LDQ, EVAL, SHIFT, CHECK, DONE; all outputs are Moore-decoded from state; strobes not listed for a state are 0.
REQ-018 IDLE: start=1 -> capture a_in/b_in into opa/opb, go CLR; start=0 -> stay.
REQ-019 CLR: dp_clr=1 -> LDA.
REQ-020 LDA: data=opa, ldA=1, ldC=1 (datapath loads count=BIT) -> LDQ.
REQ-021 LDQ: data=opb, ldQ=1, selQ=0 -> EVAL; internal iteration counter iter cleared to 0.
REQ-022 EVAL: cmp=10 -> ldM=1, selM=10; cmp=01 -> ldM=1, selM=01; cmp=00/11 -> ldM=0 -> SHIFT.
REQ-023 SHIFT: ldM=1, selM=11, ldQ=1, selQ=1, ldQ0=1, countdown=1; iter increments -> CHECK.
REQ-024 CHECK: count==0 -> DONE, err=0; else iter==BIT -> DONE, err=1; else -> EVAL.
REQ-025 DONE: done=1, err valid -> IDLE.
REQ-026 data drives 0 in all states except LDA/LDQ.
REQ-027 Latency: start accepted at edge t; done high in cycle t+3+3*BIT+1 (t+28 for BIT=8); exactly BIT shifts, each iteration EVAL/SHIFT/CHECK.
REQ-028 start while busy is ignored and not queued; start in the DONE cycle is ignored.
REQ-029 a_in/b_in changes after capture do not affect the operation in progress.
REQ-030 ldB is never asserted (B register reserved).
REQ-031 ldM and ldQ never both asserted outside SHIFT; at most one selM source per cycle.

Reset
REQ-032 clr=1 at any edge forces IDLE; busy=0, done=0, err=0, dp_clr=0, all strobes 0, data=0, opa/opb/iter=0.
REQ-033 clr mid-operation aborts with no done pulse; next start begins from CLR normally.
REQ-034 clr and start in the same cycle: clr wins, start is dropped.

Verification
REQ-035 Bench pairs the controller with a behavioural datapath; a=3, b=-4, start pulse -> done at t+28, err=0, product 16'hFFF4 (-12).
REQ-036 a=-128, b=-128 -> product 16'h4000, done at t+28; a=0, b=-1 -> product 0, no add/sub strobes with nonzero effect.
REQ-037 b=8'b01010101 -> EVAL alternates selM=10/01 with ldM=1 every iteration; exactly 8 SHIFT cycles observed.
REQ-038 Datapath model with stuck count=5 -> done after 8 iterations with err=1.
REQ-039 clr asserted in the 4th SHIFT cycle -> next cycle IDLE, busy=0, no done; fresh start a=7, b=6 -> product 42.
REQ-040 start held high continuously -> back-to-back operations each 29 cycles apart (t+28 done, t+29 next accept); start pulses during busy produce no extra done.

Source files
------------

// File: rtl/booth_controller.sv
// ---------------------------------------------------------------------------
// booth_controller
//   Sequencing FSM for a radix-2 Booth multiplier.  It drives an external
//   datapath made of A (multiplicand), M (accumulator), Q (multiplier),
//   Q0 (Booth history bit) and an iteration down-counter C.
//
//   State table
//   state | meaning
//   IDLE  | waiting for start; operands captured on acceptance
//   CLR   | one-cycle clear of all datapath registers
//   LDA   | load multiplicand into A, load C with BIT
//   LDQ   | load multiplier into Q, clear internal iteration count
//   EVAL  | Booth pair decode: 10 -> M-A, 01 -> M+A, 00/11 -> no change
//   SHIFT | arithmetic right shift of {M,Q,Q0}, decrement C
//   CHECK | decide: C exhausted -> DONE, iteration limit -> DONE with err
//   DONE  | one-cycle completion pulse
//
// Ports
//   clk, clr          clock, synchronous active-high reset
//   start             multiply request (only sampled in IDLE)
//   a_in, b_in        signed operands, captured with start
//   count             datapath down-counter value
//   cmp               {Q[0], Q0} Booth pair from datapath
//   data              operand bus to datapath (0 outside LDA/LDQ)
//   ldA..countdown    datapath load/decrement strobes
//   selM, selQ        M / Q source selects
//   dp_clr            datapath clear
//   busy, done, err   status; err only valid while done is high
// ---------------------------------------------------------------------------
module booth_controller #(
    parameter int BIT = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [BIT-1:0] a_in,
    input  logic [BIT-1:0] b_in,
    input  logic [BIT-1:0] count,
    input  logic [1:0]     cmp,
    output logic [BIT-1:0] data,
    output logic           ldA,
    output logic           ldB,
    output logic           ldM,
    output logic           ldQ,
    output logic           ldQ0,
    output logic           ldC,
    output logic           countdown,
    output logic [1:0]     selM,
    output logic           selQ,
    output logic           dp_clr,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int IW = $clog2(BIT + 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LDA,
        S_LDQ,
        S_EVAL,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [BIT-1:0]  opa;
    logic [BIT-1:0]  opb;
    logic [IW-1:0]   iter;
    logic            err_q;
    logic            count_zero;

    assign count_zero = (count == '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            iter  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opa <= a_in;
                        opb <= b_in;
                    end
                end
                S_LDQ:   iter <= '0;
                S_SHIFT: iter <= iter + IW'(1);
                S_CHECK: begin
                    // err_q is only consumed in DONE, so it is safe to
                    // update it on every CHECK pass.
                    if (count_zero) begin
                        err_q <= 1'b0;
                    end else if (iter == ITER_MAX) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        data      = '0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldM       = 1'b0;
        ldQ       = 1'b0;
        ldQ0      = 1'b0;
        ldC       = 1'b0;
        countdown = 1'b0;
        selM      = 2'b00;
        selQ      = 1'b0;
        dp_clr    = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nx = S_CLR;
            end
            S_CLR: begin
                dp_clr   = 1'b1;
                state_nx = S_LDA;
            end
            S_LDA: begin
                data     = opa;
                ldA      = 1'b1;
                ldC      = 1'b1;
                state_nx = S_LDQ;
            end
            S_LDQ: begin
                data     = opb;
                ldQ      = 1'b1;
                selQ     = 1'b0;
                state_nx = S_EVAL;
            end
            S_EVAL: begin
                case (cmp)
                    2'b10: begin
                        ldM  = 1'b1;
                        selM = 2'b10;
                    end
                    2'b01: begin
                        ldM  = 1'b1;
                        selM = 2'b01;
                    end
                    default: ;
                endcase
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                ldM       = 1'b1;
                selM      = 2'b11;
                ldQ       = 1'b1;
                selQ      = 1'b1;
                ldQ0      = 1'b1;
                countdown = 1'b1;
                state_nx  = S_CHECK;
            end
            S_CHECK: begin
                if (count_zero || (iter == ITER_MAX)) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_EVAL;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                err      = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
